// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter FSM states,
// byte width and the baud divider values used by benches.
package uart_pkg;

    localparam int unsigned UART_BYTE_W     = 8;
    localparam int unsigned BAUD_DIV_50MHZ  = 434;
    localparam int unsigned BAUD_DIV_200MHZ = 1736;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set bit of (req & mask),
// searching upward from ptr with wrap-around.
module uart_rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned ID_W = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [ID_W-1:0] ptr_i,
    input  logic [NREQ-1:0] mask_i,
    output logic            found_o,
    output logic [ID_W-1:0] idx_o
);

    logic [NREQ-1:0] cand;
    logic [NREQ-1:0] rot;

    assign cand = req_i & mask_i;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        // Rotate so bit 0 is the requester at ptr; the lowest set bit wins.
        rot     = NREQ'({cand, cand} >> ptr_i);
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found_o && rot[k]) begin
                found_o = 1'b1;
                idx_o   = ID_W'((32'(ptr_i) + k) % NREQ);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter sharing one uart_writer between NREQ
// byte streams; sequences wr_en/busy one byte at a time with a busy-rise timeout.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NREQ         = 4,
    parameter int unsigned ID_W         = 2,
    parameter int unsigned BUSY_TIMEOUT = 16,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NREQ-1:0]             req_valid_i,
    input  logic [UART_BYTE_W*NREQ-1:0] req_data_i,
    input  logic [NREQ-1:0]             req_last_i,
    output logic [NREQ-1:0]             req_ready_o,
    output logic [UART_BYTE_W-1:0]      wr_din_o,
    output logic                        wr_en_o,
    input  logic                        wr_busy_i,
    output logic [ID_W-1:0]             owner_o,
    output logic                        locked_o,
    output logic                        timeout_err_o,
    output logic [CNT_W-1:0]            tx_count_o
);

    localparam int unsigned TMR_W = (BUSY_TIMEOUT > 2) ? $clog2(BUSY_TIMEOUT) : 1;

    arb_state_e             state_q, state_d;
    logic [ID_W-1:0]        rr_q, rr_d;
    logic [ID_W-1:0]        owner_q, owner_d;
    logic                   locked_q, locked_d;
    logic [UART_BYTE_W-1:0] din_q, din_d;
    logic                   terr_q, terr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [TMR_W-1:0]       tmr_q, tmr_d;

    logic                   pick_found;
    logic [ID_W-1:0]        pick_idx;
    logic [NREQ-1:0]        pick_mask;
    logic [ID_W-1:0]        pick_ptr;
    logic [NREQ-1:0]        sel_oh;

    // While a packet is open only the owner may be granted.
    assign pick_mask = locked_q ? (NREQ'(1) << owner_q) : '1;
    assign pick_ptr  = locked_q ? owner_q : rr_q;
    assign sel_oh    = NREQ'(1) << pick_idx;

    uart_rr_pick #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_pick (
        .req_i   (req_valid_i),
        .ptr_i   (pick_ptr),
        .mask_i  (pick_mask),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        owner_d     = owner_q;
        locked_d    = locked_q;
        din_d       = din_q;
        terr_d      = terr_q;
        cnt_d       = cnt_q;
        tmr_d       = tmr_q;
        req_ready_o = '0;
        wr_en_o     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found && !rst_i) begin
                    req_ready_o = sel_oh;
                    din_d       = UART_BYTE_W'(req_data_i >> {pick_idx, 3'b000});
                    owner_d     = pick_idx;
                    locked_d    = ~|(req_last_i & sel_oh);
                    if (!locked_q) begin
                        rr_d = (pick_idx == ID_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                wr_en_o = !rst_i;
                cnt_d   = cnt_q + 1'b1;
                tmr_d   = '0;
                state_d = WAIT_HI;
            end
            WAIT_HI: begin
                if (wr_busy_i) begin
                    state_d = WAIT_LO;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                    if (tmr_d == TMR_W'(BUSY_TIMEOUT - 1)) begin
                        terr_d   = 1'b1;
                        locked_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
            end
            WAIT_LO: begin
                if (!wr_busy_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            rr_q     <= '0;
            owner_q  <= '0;
            locked_q <= 1'b0;
            din_q    <= '0;
            terr_q   <= 1'b0;
            cnt_q    <= '0;
            tmr_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            owner_q  <= owner_d;
            locked_q <= locked_d;
            din_q    <= din_d;
            terr_q   <= terr_d;
            cnt_q    <= cnt_d;
            tmr_q    <= tmr_d;
        end
    end

    assign wr_din_o      = din_q;
    assign owner_o       = owner_q;
    assign locked_o      = locked_q;
    assign timeout_err_o = terr_q;
    assign tx_count_o    = cnt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: timestamp-level reference model, requester
// queues and a scripted/random writer busy profile, checked every cycle.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int ID_W = 2;
    localparam int BT   = 16;
    localparam int CNTW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid, req_last, req_ready;
    logic [8*NREQ-1:0] req_data;
    logic [7:0]        wr_din;
    logic              wr_en, wr_busy;
    logic [ID_W-1:0]   owner;
    logic              locked, terr;
    logic [CNTW-1:0]   tx_count;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NREQ         (NREQ),
        .ID_W         (ID_W),
        .BUSY_TIMEOUT (BT),
        .CNT_W        (CNTW)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_data_i    (req_data),
        .req_last_i    (req_last),
        .req_ready_o   (req_ready),
        .wr_din_o      (wr_din),
        .wr_en_o       (wr_en),
        .wr_busy_i     (wr_busy),
        .owner_o       (owner),
        .locked_o      (locked),
        .timeout_err_o (terr),
        .tx_count_o    (tx_count)
    );

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    // Requester byte queues, entries are {last, data}.
    logic [8:0]      q [NREQ][$];
    logic [NREQ-1:0] gate = '0;
    logic            rst_s = 1'b1;
    int              wmode = 0, fg = 0, fL = 1;

    // Reference model: expected registered outputs plus event timestamps.
    logic [7:0]  m_din = '0;
    int          m_owner = 0, m_rr = 0;
    logic        m_locked = 1'b0, m_terr = 1'b0;
    logic [15:0] m_cnt = '0;
    int          free_at = 0, wren_at = -1, to_at = -1, b_lo = 1, b_hi = 0;

    logic [7:0]      wlog [$];
    int              acc_dut = -1, acc_cyc = 0, wren_cyc = 0, last_cyc = 0;
    logic [NREQ-1:0] s_ready;
    logic            s_wren, s_terr, s_locked;
    logic [15:0]     s_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: dut=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Nearest candidate at or after rr in circular distance.
    function automatic int pick(input logic [NREQ-1:0] cand, input int rr);
        int best = -1;
        int bd   = NREQ;
        for (int i = 0; i < NREQ; i++) begin
            if (cand[i] && ((i - rr + NREQ) % NREQ) < bd) begin
                bd   = (i - rr + NREQ) % NREQ;
                best = i;
            end
        end
        return best;
    endfunction

    task automatic step();
        logic [NREQ-1:0]   v, l, cand, exp_rdy;
        logic [8*NREQ-1:0] d;
        logic [8:0]        hd;
        int                a, g, len;
        logic              e_wren, to;
        @(negedge clk);
        for (int i = 0; i < NREQ; i++) begin
            hd = (q[i].size() > 0) ? q[i][0] : 9'h000;
            v[i] = (q[i].size() > 0) && !gate[i];
            d[8*i +: 8] = hd[7:0];
            l[i] = hd[8];
        end
        rst       = rst_s;
        req_valid = v;
        req_data  = d;
        req_last  = l;
        wr_busy   = !rst_s && cyc >= b_lo && cyc <= b_hi;
        #1;
        exp_rdy = '0;
        a = -1;
        if (!rst_s && cyc >= free_at) begin
            cand = m_locked ? (v & (NREQ'(1) << m_owner)) : v;
            a = pick(cand, m_rr);
            if (a >= 0) exp_rdy[a] = 1'b1;
        end
        e_wren = !rst_s && cyc == wren_at;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        chk("wr_en", 32'(wr_en), 32'(e_wren));
        chk("wr_din", 32'(wr_din), 32'(m_din));
        chk("owner", 32'(owner), m_owner);
        chk("locked", 32'(locked), 32'(m_locked));
        chk("timeout_err", 32'(terr), 32'(m_terr));
        chk("tx_count", 32'(tx_count), 32'(m_cnt));
        s_ready  = req_ready;
        s_wren   = wr_en;
        s_terr   = terr;
        s_locked = locked;
        s_cnt    = tx_count;
        last_cyc = cyc;
        if (wr_en) begin
            wlog.push_back(wr_din);
            wren_cyc = cyc;
        end
        acc_dut = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i] && v[i]) begin
                void'(q[i].pop_front());
                acc_dut = i;
                acc_cyc = cyc;
            end
        end
        if (rst_s) begin
            m_din = '0; m_owner = 0; m_locked = 1'b0; m_terr = 1'b0; m_cnt = '0; m_rr = 0;
            free_at = cyc + 1; wren_at = -1; to_at = -1; b_lo = 1; b_hi = 0;
        end else begin
            if (e_wren) m_cnt = m_cnt + 16'd1;
            if (a >= 0) begin
                m_din   = d[8*a +: 8];
                m_owner = a;
                if (!m_locked) m_rr = (a + 1) % NREQ;
                m_locked = !l[a];
                wren_at  = cyc + 1;
                g   = $urandom_range(0, 3);
                len = $urandom_range(1, 4);
                to  = 1'b0;
                case (wmode)
                    1: begin g = fg; len = fL; end
                    2: to = 1'b1;
                    3: to = ($urandom_range(0, 24) == 0);
                    default: ;
                endcase
                if (to) begin
                    b_lo = 1; b_hi = 0;
                    to_at   = cyc + BT + 1;
                    free_at = to_at;
                end else begin
                    b_lo    = cyc + 2 + g;
                    b_hi    = b_lo + len - 1;
                    free_at = b_hi + 2;
                end
            end
            if (cyc + 1 == to_at) begin
                m_terr   = 1'b1;
                m_locked = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic drain(input int max);
        int n = 0;
        while (!(q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0 &&
                 q[3].size() == 0 && cyc >= free_at && cyc > b_hi)) begin
            if (n == max) begin
                nvec++; nerr++;
                $display("FAIL drain: still busy after %0d cycles (cycle %0d)", max, cyc);
                return;
            end
            step();
            n++;
        end
    endtask

    task automatic do_reset();
        rst_s = 1'b1;
        step();
        step();
        rst_s = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_rr [8];
        logic [7:0] exp_lk [4];
        int         t0, n_rdy0, n_wren, n;
        logic       saw_lock;

        rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; wr_busy = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();
        chk("reset_cnt", 32'(s_cnt), 0);
        chk("reset_ready", 32'(s_ready), 0);

        // Single byte, busy rises two cycles after acceptance.
        wmode = 1; fg = 0; fL = 3;
        wlog.delete();
        q[0].push_back({1'b1, 8'hA5});
        drain(100);
        chk("single_len", wlog.size(), 1);
        chk("single_data", (wlog.size() > 0) ? 32'(wlog[0]) : 32'hDEAD, 32'hA5);
        chk("single_wr_en_lat", wren_cyc - acc_cyc, 1);
        step();
        chk("single_cnt", 32'(s_cnt), 1);
        chk("single_locked", 32'(s_locked), 0);

        // Round robin from rr_ptr=0.
        do_reset();
        wmode = 0;
        wlog.delete();
        exp_rr = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h11, 8'h12, 8'h13};
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NREQ; i++) q[i].push_back({1'b1, 8'(8'h10 + i)});
        drain(300);
        chk("rr_len", wlog.size(), 8);
        for (int i = 0; i < 8; i++)
            chk("rr_order", (i < wlog.size()) ? 32'(wlog[i]) : 32'hDEAD, 32'(exp_rr[i]));

        // Packet lock: req1 packet must not be interleaved with req2.
        wlog.delete();
        exp_lk = '{8'h01, 8'h02, 8'h03, 8'hFF};
        q[1].push_back({1'b0, 8'h01});
        q[1].push_back({1'b0, 8'h02});
        q[1].push_back({1'b1, 8'h03});
        q[2].push_back({1'b1, 8'hFF});
        saw_lock = 1'b0;
        for (int k = 0; k < 300 && !(q[1].size() == 0 && q[2].size() == 0 && cyc >= free_at); k++) begin
            step();
            if (s_locked) saw_lock = 1'b1;
        end
        drain(100);
        chk("lock_seen", 32'(saw_lock), 1);
        chk("lock_len", wlog.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("lock_order", (i < wlog.size()) ? 32'(wlog[i]) : 32'hDEAD, 32'(exp_lk[i]));

        // Lock stall: owner drops valid mid-packet, req0 must wait.
        wlog.delete();
        q[1].push_back({1'b0, 8'h01});
        q[1].push_back({1'b1, 8'h02});
        n = 0;
        while (q[1].size() != 1 && n < 50) begin step(); n++; end
        gate[1] = 1'b1;
        q[0].push_back({1'b1, 8'h55});
        repeat (20) step();
        n_rdy0 = 0; n_wren = 0;
        repeat (200) begin
            step();
            if (s_ready[0]) n_rdy0++;
            if (s_wren) n_wren++;
        end
        chk("stall_ready0", n_rdy0, 0);
        chk("stall_wr_en", n_wren, 0);
        gate[1] = 1'b0;
        drain(100);
        chk("stall_len", wlog.size(), 3);
        chk("stall_resume", (wlog.size() > 1) ? 32'(wlog[1]) : 32'hDEAD, 32'h02);
        chk("stall_next", (wlog.size() > 2) ? 32'(wlog[2]) : 32'hDEAD, 32'h55);

        // Timeout: writer never raises busy.
        wlog.delete();
        wmode = 2;
        q[3].push_back({1'b0, 8'h77});
        n = 0;
        while (acc_dut != 3 && n < 100) begin step(); n++; end
        t0 = acc_cyc;
        wmode = 0;
        q[0].push_back({1'b1, 8'h66});
        n = 0;
        while (!s_terr && n < 40) begin step(); n++; end
        chk("timeout_lat", last_cyc - t0, BT + 1);
        chk("timeout_unlock", 32'(s_locked), 0);
        drain(100);
        chk("timeout_next", (wlog.size() > 1) ? 32'(wlog[1]) : 32'hDEAD, 32'h66);
        chk("timeout_sticky", 32'(s_terr), 1);

        // Reset while the writer is busy.
        wmode = 1; fg = 0; fL = 20;
        q[2].push_back({1'b1, 8'h33});
        n = 0;
        while (!(cyc >= b_lo + 2 && b_hi >= b_lo) && n < 50) begin step(); n++; end
        q[1].push_back({1'b1, 8'h22});
        q[3].push_back({1'b1, 8'h44});
        rst_s = 1'b1;
        step();
        rst_s = 1'b0;
        wmode = 0;
        step();
        chk("rst_cnt", 32'(s_cnt), 0);
        chk("rst_terr", 32'(s_terr), 0);
        chk("rst_first_grant", acc_dut, 1);
        drain(200);

        // Randomised traffic with occasional writer timeouts and valid drops.
        wmode = 3;
        repeat (2500) begin
            for (int i = 0; i < NREQ; i++) begin
                if (q[i].size() == 0 && $urandom_range(0, 3) == 0) begin
                    n = $urandom_range(1, 3);
                    for (int b = 0; b < n; b++)
                        q[i].push_back({(b == n - 1) ? 1'b1 : 1'b0, 8'($urandom)});
                end
                if ($urandom_range(0, 15) == 0) gate[i] = ~gate[i];
            end
            step();
        end
        gate = '0;
        drain(3000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
